// File: rtl/multdiv_pkg.sv
// Shared constants and FSM encoding for the iterative multiply/divide unit.
package multdiv_pkg;

  localparam int DEF_WIDTH = 32;  // operand/result width
  localparam int DEF_ITER  = 32;  // iteration cycles per operation
  localparam int CNT_W     = 6;   // iteration counter width

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } md_state_e;

  // Two's-complement magnitude; 0x80000000 maps to itself as an unsigned value.
  function automatic logic [DEF_WIDTH-1:0] mag(input logic [DEF_WIDTH-1:0] x);
    return x[DEF_WIDTH-1] ? -x : x;
  endfunction

endpackage

// File: rtl/multdiv_counter.sv
// Iteration counter: counts 0..ITER-1 while enabled, holds at terminal count.
module multdiv_counter
  import multdiv_pkg::*;
#(
  parameter int ITER = DEF_ITER
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt;

  assign tc = (cnt == CNT_W'(ITER - 1));

  // Saturate at terminal count so the last iteration never rolls into another.
  always_ff @(posedge clk) begin
    if (clr)
      cnt <= '0;
    else if (en && !tc)
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/multdiv_unit.sv
// Signed 32-bit iterative multiplier / divider, one bit per cycle.
// Multiply: shift-add on magnitudes. Divide: restoring on magnitudes.
// acc doubles as {hi,lo} product for multiply and {remainder,quotient} for divide.
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ITER  = DEF_ITER
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  md_state_e            state;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     opnd;   // multiplicand or divisor magnitude
  logic                 neg;    // result sign
  logic                 tc;
  logic                 iter_en;

  logic                 go_mult, go_div;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_nxt, mul_fin;
  logic [WIDTH:0]       rem_sh, rem_diff;
  logic [2*WIDTH-1:0]   div_nxt;
  logic [WIDTH-1:0]     q_fin;

  assign go_mult = ctrl_MULT & ~ctrl_DIV;
  assign go_div  = ctrl_DIV & ~ctrl_MULT;
  assign iter_en = (state == S_MULT) || (state == S_DIV);

  multdiv_counter #(.ITER(ITER)) u_cnt (
    .clk (clk),
    .clr (clr | ~iter_en),
    .en  (iter_en),
    .tc  (tc)
  );

  // One multiply step: conditionally add multiplicand to the high half, shift right.
  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_nxt = {mul_sum, acc[WIDTH-1:1]};
    mul_fin = neg ? -mul_nxt : mul_nxt;
  end

  // One restoring-divide step: shift in next dividend bit, trial subtract.
  always_comb begin
    rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, opnd};
    if (rem_diff[WIDTH])
      div_nxt = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else
      div_nxt = {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    q_fin = neg ? -div_nxt[WIDTH-1:0] : div_nxt[WIDTH-1:0];
  end

  // Control FSM with registered outputs; results held until the next completion.
  always_ff @(posedge clk) begin
    if (clr) begin
      state          <= S_IDLE;
      acc            <= '0;
      opnd           <= '0;
      neg            <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go_mult) begin
            state <= S_MULT;
            busy  <= 1'b1;
            acc   <= {{WIDTH{1'b0}}, mag(data_operandB)};
            opnd  <= mag(data_operandA);
            neg   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
          end else if (go_div) begin
            busy <= 1'b1;
            acc  <= {{WIDTH{1'b0}}, mag(data_operandA)};
            opnd <= mag(data_operandB);
            neg  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            if (data_operandB == '0) begin
              state          <= S_DONE;
              data_resultRDY <= 1'b1;
              data_result    <= '0;
              data_exception <= 1'b1;
            end else begin
              state <= S_DIV;
            end
          end
        end
        S_MULT: begin
          acc <= mul_nxt;
          if (tc) begin
            state          <= S_DONE;
            data_resultRDY <= 1'b1;
            data_result    <= mul_fin[WIDTH-1:0];
            data_exception <= (mul_fin[2*WIDTH-1:WIDTH] != {WIDTH{mul_fin[WIDTH-1]}});
          end
        end
        S_DIV: begin
          acc <= div_nxt;
          if (tc) begin
            state          <= S_DONE;
            data_resultRDY <= 1'b1;
            data_result    <= q_fin;
            // Only -2^31 / -1 yields a positive quotient with the top bit set.
            data_exception <= ~neg & div_nxt[WIDTH-1];
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
